// File: rtl/mix_columns_seq.sv
// Iterative AES forward MixColumns engine.
// Takes one 128-bit state over a valid/ready handshake, transforms
// COLS_PER_CYCLE columns per clock in a working register, then holds the
// result until the consumer accepts it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. in_ready depends only on the FSM
// state, never on in_valid. out_valid, once high, stays high with out_data
// stable until the edge where out_ready is high.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // Only widths that divide the four columns evenly are supported.
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the first column of the final processing step, and the
  // per-step index advance (4 wraps to 0, which is harmless because the
  // single step is also the last one).
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     idx_q;
  logic [1:0]     idx_d;
  logic [127:0]   work_q;
  logic [127:0]   work_d;

  // GF(2^8) multiply by 2 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by 3.
  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // One column of MixColumns; row 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ mul3(a1)  ^ a2        ^ a3,
            a0        ^ xtime(a1) ^ mul3(a2)  ^ a3,
            a0        ^ a1        ^ xtime(a2) ^ mul3(a3),
            mul3(a0)  ^ a1        ^ a2        ^ xtime(a3)};
  endfunction

  // Transform columns idx .. idx+COLS_PER_CYCLE-1 of the state in place.
  // Column c lives at bits [127-32c -: 32]; the 2-bit column number wraps.
  function automatic logic [127:0] mix_span(input logic [127:0] s,
                                            input logic [1:0]   idx);
    logic [127:0] r;
    logic [1:0]   col;
    r = s;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col = idx + 2'(k);
      r[127 - 32*int'(col) -: 32] = mix_col(s[127 - 32*int'(col) -: 32]);
    end
    return r;
  endfunction

  // Next-state, column index and working-register update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          idx_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = mix_span(work_q, idx_q);
        idx_d  = idx_q + IDX_STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, index and working register; reset discards any in-flight state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      work_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: directed FIPS-197 and single-column vectors,
// backpressure, back-to-back streaming, asynchronous reset mid-operation
// and a random sweep. Inputs change 1 time unit after a rising edge;
// outputs are checked on the falling edge by the monitor.
module tb_mix_columns_seq;

  localparam int CPC         = 1;
  localparam int PROC_CYCLES = 4 / CPC;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] BP_IN    = 128'hdb135345f20a225cd4d4d4d52d26314c;
  localparam logic [127:0] BP_OUT   = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
  localparam logic [127:0] MIX_IN   = 128'hf20a225cdb135345c6c6c6c601010101;
  localparam logic [127:0] MIX_OUT  = 128'h9fdc589d8e4da1bcc6c6c6c601010101;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] src_q[$];
  logic [127:0] mon_exp;
  logic [127:0] mon_src;
  bit           rand_stall = 1'b0;

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference GF(2^8) multiply: shift-and-add with reduction by 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Reference (inverse) MixColumns as a circulant matrix product.
  function automatic logic [127:0] model_mc(input logic [127:0] s, input bit inverse);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inverse) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(base[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Scoreboard monitor: compare every accepted output against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got=%h expected=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_src = src_q.pop_front();
        check("result", out_data, mon_exp);
        check("inverse_roundtrip", model_mc(out_data, 1'b1), mon_src);
      end
    end
  end

  // Random consumer stalls while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Driver: present one state when the DUT is ready; called at edge+1.
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 expected=1");
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back(e);
      src_q.push_back(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  logic [31:0]  col_in  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                                32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
  logic [31:0]  col_out [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                                32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
  logic [127:0] b2b_in  [3];
  logic [127:0] b2b_out [3];

  initial begin
    logic [127:0] d;
    logic [127:0] e;
    int           n;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 round 1 with latency measurement
    out_ready = 1'b1;
    send(FIPS_IN, FIPS_OUT);
    check("accept_busy", 128'(busy), 128'd1);
    check("accept_in_ready", 128'(in_ready), 128'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 128'(n), 128'(PROC_CYCLES));
    wait_drain();

    // known single columns in every column position
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) begin
        d = {4{32'h01010101}};
        e = d;
        d[127 - 32*p -: 32] = col_in[i];
        e[127 - 32*p -: 32] = col_out[i];
        send(d, e);
      end
    end
    wait_drain();

    // backpressure: hold the result for 10 cycles, ignore a new input
    out_ready = 1'b0;
    send(BP_IN, BP_OUT);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        in_data  = FIPS_IN;
      end
      if (k == 4) in_valid = 1'b0;
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_data", out_data, BP_OUT);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    check("bp_pulse_ignored", 128'(busy), 128'd0);

    // back-to-back with in_valid and out_ready held high
    b2b_in[0] = FIPS_IN; b2b_out[0] = FIPS_OUT;
    b2b_in[1] = BP_IN;   b2b_out[1] = BP_OUT;
    b2b_in[2] = MIX_IN;  b2b_out[2] = MIX_OUT;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = b2b_in[i];
      exp_q.push_back(b2b_out[i]);
      src_q.push_back(b2b_in[i]);
      n = 0;
      while (!in_ready && n < 50) begin
        if (out_valid) check("b2b_done_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        n++;
      end
      check("b2b_wait", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      check("b2b_busy_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    wait_drain();

    // asynchronous reset while BUSY at column 2
    send(FIPS_IN, FIPS_OUT);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    src_q.delete();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_in_ready", 128'(in_ready), 128'd1);
    check("arst_out_data", out_data, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_output", 128'(out_valid), 128'd0);
    send(BP_IN, BP_OUT);
    wait_drain();

    // random states with random consumer stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(d, model_mc(d, 1'b0));
    end
    wait_drain();
    rand_stall = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative AES forward MixColumns engine. It is the encrypt-direction counterpart of the inverse-MixColumns path built from the GF(2^8) multiply-by-9/11/13/14 lookups.
- Accepts one 128-bit state through a valid/ready handshake, processes COLS_PER_CYCLE columns per clock, and holds the result until the downstream consumer accepts it.
- Sits between ShiftRows and AddRoundKey in the iterative encryption datapath.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  state after ShiftRows.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  MixColumns result.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Byte mapping:
  - Column c occupies bits [127-32c -: 32].
  - Row r of column c occupies bits [127-32c-8r -: 8], so row 0 is the MS byte.
- Column math, with inputs a0..a3 and outputs b0..b3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- GF(2^8) arithmetic:
  - 2x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 3x = 2x ^ x.
  - Pure 8-bit XOR logic; no lookup tables.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - If in_valid is high at an edge, in_data is captured into the working register, the column index is cleared to 0, and the FSM moves to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge transforms columns idx..idx+COLS_PER_CYCLE-1 in place, then idx += COLS_PER_CYCLE.
  - On the edge that processes column 3, the FSM moves to DONE.
- DONE:
  - out_valid = 1 and out_data = working register, held stable until out_ready.
  - An edge with out_ready = 1 returns the FSM to IDLE and drops out_valid.
- Latency:
  - Acceptance edge E0; result visible after edge E(4/COLS_PER_CYCLE).
  - That is 4, 2 or 1 cycles of processing.
  - Minimum initiation interval is 4/COLS_PER_CYCLE + 2 cycles.
- Backpressure: out_ready low in DONE holds the result indefinitely; in_ready stays 0 throughout.
- Simultaneous events: in_valid while BUSY or DONE is ignored, because in_ready = 0. There is no skid buffer and no input overwrite.
- out_ready while not in DONE has no effect.
- Column index wraps naturally (2-bit); no out-of-range column is ever processed.
- Reset:
  - Values: FSM = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 128'h0, column index = 0.
  - Reset asserted mid-BUSY or mid-DONE discards the in-flight state immediately (asynchronously).
  - No output is produced for the discarded state after reset release.
- out_data is driven from the working register only; it may change while BUSY but is valid only while out_valid = 1.

Test Plan:
- FIPS-197 App. B round 1, out_ready tied 1:
  - in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5 -> out_data = 128'h046681e5e0cb199a48f8d37a2806264c.
  - out_valid rises exactly 4 edges after acceptance for COLS_PER_CYCLE = 1, 2 edges for 2, 1 edge for 4.
- Known single columns placed in all four column positions:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - 01010101 -> 01010101
  - c6c6c6c6 -> c6c6c6c6
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready stays 0.
  - A new in_valid pulse during this window is not accepted.
  - After out_ready = 1 for one edge -> IDLE, in_ready = 1 on the next cycle.
- Back-to-back:
  - Stream three states with in_valid and out_ready held high -> three correct results in order.
  - in_ready deasserted during each BUSY/DONE.
- Reset mid-operation:
  - Assert rst_n = 0 asynchronously during BUSY at column 2 -> out_valid = 0, busy = 0, in_ready = 1, out_data = 0 without waiting for a clock edge.
  - After release, a fresh input produces the correct result.
- Random check: 1000 random states, with random out_ready stalls, compared against a software MixColumns model. The bench also confirms that applying the inverse MixColumns path to out_data returns in_data.
